// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the store buffer: entry layout, pointer
// and count widths, and the circular pointer increment.
package store_buf_pkg;

  localparam int DEPTH   = 4;
  localparam int AW      = 32;
  localparam int DW      = 32;
  localparam int WORD_AW = AW - 2;
  localparam int PW      = $clog2(DEPTH);
  localparam int CW      = $clog2(DEPTH + 1);

  typedef struct packed {
    logic               valid;
    logic [WORD_AW-1:0] waddr;
    logic [DW-1:0]      data;
  } sb_entry_t;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// Store-side, load-forwarding and memory-drain signals of the store buffer.
// slave: the buffer itself; master: pipeline plus data memory.
interface store_buffer_if;
  import store_buf_pkg::*;

  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_ready;
  logic          stall;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic [CW-1:0] count;
  logic          empty;

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_ready,
    output st_ready, stall, ld_hit, ld_data, mem_valid, mem_addr, mem_data,
           count, empty
  );

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_ready,
    input  st_ready, stall, ld_hit, ld_data, mem_valid, mem_addr, mem_data,
           count, empty
  );

endinterface

// File: rtl/store_buffer_fwd_match.sv
// Youngest-first load forwarding match over the buffered entries.
// Only the count live entries ending just below wr_ptr are searched.
module sb_fwd_match
  import store_buf_pkg::*;
(
  input  sb_entry_t          entries_i [DEPTH],
  input  logic [PW-1:0]      wr_ptr_i,
  input  logic [CW-1:0]      count_i,
  input  logic [WORD_AW-1:0] ld_waddr_i,
  output logic               hit_o,
  output logic [DW-1:0]      data_o
);

  logic [PW-1:0] idx;

  // Walk backward from the youngest entry; first match wins
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = wr_ptr_i - PW'(i + 1);
      if (!hit_o && (CW'(i) < count_i) && entries_i[idx].valid &&
          (entries_i[idx].waddr == ld_waddr_i)) begin
        hit_o  = 1'b1;
        data_o = entries_i[idx].data;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer: circular FIFO of word stores draining to data
// memory over valid/ready, with youngest-match load forwarding.
// Optional macro STORE_BUF_COALESCE_EN: a store hitting the youngest
// non-head entry overwrites its data in place instead of allocating.
module store_buffer
  import store_buf_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  sb
);

  sb_entry_t          entries_q [DEPTH];
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [WORD_AW-1:0] st_waddr;
  logic               enq, deq, coal;
  logic               unused_addr_lsbs;

  assign st_waddr         = sb.st_addr[AW-1:2];
  assign unused_addr_lsbs = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

`ifdef STORE_BUF_COALESCE_EN
  logic [PW-1:0] last_ptr;
  assign last_ptr = wr_ptr_q - 1'b1;
  // count>=2 keeps the head (possibly mid-handshake) from being rewritten
  assign coal = sb.st_valid && (count_q >= CW'(2)) && entries_q[last_ptr].valid &&
                (entries_q[last_ptr].waddr == st_waddr);
`else
  assign coal = 1'b0;
`endif

  assign sb.st_ready = (count_q != CW'(DEPTH)) | coal;
  assign sb.stall    = sb.st_valid & ~sb.st_ready;
  assign sb.mem_valid = (count_q != '0);
  assign sb.empty     = (count_q == '0);
  assign sb.count     = count_q;
  assign sb.mem_addr  = {entries_q[rd_ptr_q].waddr, 2'b00};
  assign sb.mem_data  = entries_q[rd_ptr_q].data;

  assign enq = sb.st_valid & sb.st_ready & ~coal;
  assign deq = sb.mem_valid & sb.mem_ready;

  // Pointer and occupancy next-state
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (deq) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({enq, deq})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers; payloads are left unreset, only valid bits clear
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) entries_q[i].valid <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (deq) entries_q[rd_ptr_q].valid <= 1'b0;
      if (enq) begin
        entries_q[wr_ptr_q].valid <= 1'b1;
        entries_q[wr_ptr_q].waddr <= st_waddr;
        entries_q[wr_ptr_q].data  <= sb.st_data;
      end
`ifdef STORE_BUF_COALESCE_EN
      if (coal) entries_q[last_ptr].data <= sb.st_data;
`endif
    end
  end

  sb_fwd_match u_fwd (
    .entries_i  (entries_q),
    .wr_ptr_i   (wr_ptr_q),
    .count_i    (count_q),
    .ld_waddr_i (sb.ld_addr[AW-1:2]),
    .hit_o      (sb.ld_hit),
    .data_o     (sb.ld_data)
  );

endmodule

// File: tb/tb_store_buffer.sv
// Scoreboard bench for store_buffer: expected memory writes are queued as
// stores are issued; a monitor pops and compares on every drain handshake.
module tb_store_buffer;
  import store_buf_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  store_buffer_if sb_if ();

  store_buffer dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    sb_if.st_valid = 1'b1;
    sb_if.st_addr  = a;
    sb_if.st_data  = d;
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && sb_if.mem_valid && sb_if.mem_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL mem_unexpected: got write addr 0x%0h data 0x%0h, expected none",
                   sb_if.mem_addr, sb_if.mem_data);
        end else begin
          e = exp_q.pop_front();
          chk("mem_addr", sb_if.mem_addr, e.addr);
          chk("mem_data", sb_if.mem_data, e.data);
        end
      end
    end
  endtask

  task automatic wait_empty(input string name);
    for (int k = 0; k < 20 && !sb_if.empty; k++) step();
    neg();
    chk(name, sb_if.empty, 1);
    step();
  endtask

  initial begin
    reset           = 1'b1;
    sb_if.st_valid  = 1'b0;
    sb_if.st_addr   = '0;
    sb_if.st_data   = '0;
    sb_if.ld_addr   = '0;
    sb_if.mem_ready = 1'b0;
    fork monitor(); join_none

    step(); step();
    reset = 1'b0;
    neg();
    chk("rst_count", sb_if.count, 0);
    chk("rst_empty", sb_if.empty, 1);
    chk("rst_st_ready", sb_if.st_ready, 1);
    chk("rst_stall", sb_if.stall, 0);
    chk("rst_mem_valid", sb_if.mem_valid, 0);
    chk("rst_ld_hit", sb_if.ld_hit, 0);
    step();

    // single store with memory ready: one-cycle enqueue latency, no bypass
    sb_if.mem_ready = 1'b1;
    store(32'h64, 32'h19);
    push(32'h64, 32'h19);
    neg();
    chk("t1_stall", sb_if.stall, 0);
    chk("t1_mem_valid_pre", sb_if.mem_valid, 0);
    step();
    sb_if.st_valid = 1'b0;
    neg();
    chk("t1_mem_valid", sb_if.mem_valid, 1);
    chk("t1_count", sb_if.count, 1);
    step();
    neg();
    chk("t1_count_end", sb_if.count, 0);
    step();

    // fill to full, fifth store stalls until one drain
    sb_if.mem_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      store(32'h100 + 32'(4 * k), 32'(k + 1));
      if (k < 4) push(32'h100 + 32'(4 * k), 32'(k + 1));
      neg();
      if (k < 4) begin
        chk("t2_st_ready", sb_if.st_ready, 1);
        chk("t2_stall", sb_if.stall, 0);
      end else begin
        chk("t2_full_count", sb_if.count, 4);
        chk("t2_full_ready", sb_if.st_ready, 0);
        chk("t2_full_stall", sb_if.stall, 1);
      end
      step();
    end
    sb_if.mem_ready = 1'b1;
    neg();
    chk("t2_stall_on_drain", sb_if.stall, 1);
    step();
    push(32'h110, 32'h5);
    neg();
    chk("t2_count_after_drain", sb_if.count, 3);
    chk("t2_accept_ready", sb_if.st_ready, 1);
    chk("t2_accept_stall", sb_if.stall, 0);
    step();
    sb_if.st_valid = 1'b0;
    wait_empty("t2_drain");

    // forwarding: youngest match, same-cycle store does not forward
    sb_if.mem_ready = 1'b0;
    store(32'h200, 32'hA);
    push(32'h200, 32'hA);
    sb_if.ld_addr = 32'h200;
    neg();
    chk("t3_same_cycle_hit", sb_if.ld_hit, 0);
    step();
    store(32'h200, 32'hB);
    push(32'h200, 32'hB);
    neg();
    chk("t3_old_hit", sb_if.ld_hit, 1);
    chk("t3_old_data", sb_if.ld_data, 32'hA);
    step();
    sb_if.st_valid = 1'b0;
    sb_if.ld_addr  = 32'h202;
    neg();
    chk("t3_young_hit", sb_if.ld_hit, 1);
    chk("t3_young_data", sb_if.ld_data, 32'hB);
    step();
    sb_if.ld_addr = 32'h204;
    neg();
    chk("t3_miss_hit", sb_if.ld_hit, 0);
    chk("t3_miss_data", sb_if.ld_data, 0);
    step();
    sb_if.mem_ready = 1'b1;
    wait_empty("t3_drain");

    // backpressure: head stable, then head forwards during its dequeue
    sb_if.mem_ready = 1'b0;
    store(32'h300, 32'h55);
    push(32'h300, 32'h55);
    step();
    sb_if.st_valid = 1'b0;
    sb_if.ld_addr  = 32'h300;
    for (int k = 0; k < 3; k++) begin
      neg();
      chk("t4_hold_valid", sb_if.mem_valid, 1);
      chk("t4_hold_addr", sb_if.mem_addr, 32'h300);
      chk("t4_hold_data", sb_if.mem_data, 32'h55);
      step();
    end
    sb_if.mem_ready = 1'b1;
    neg();
    chk("t4_head_fwd_hit", sb_if.ld_hit, 1);
    chk("t4_head_fwd_data", sb_if.ld_data, 32'h55);
    step();
    neg();
    chk("t4_after_deq_hit", sb_if.ld_hit, 0);
    step();

    // pointer wrap: ten back-to-back stores with memory ready
    for (int k = 0; k < 10; k++) begin
      store(32'h800 + 32'(4 * k), 32'hC0 + 32'(k));
      push(32'h800 + 32'(4 * k), 32'hC0 + 32'(k));
      neg();
      chk("t5_wrap_stall", sb_if.stall, 0);
      step();
    end
    sb_if.st_valid = 1'b0;
    wait_empty("t5_drain");

    // reset with three buffered stores discards them
    sb_if.mem_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      store(32'h400 + 32'(4 * k), 32'h41 + 32'(k));
      step();
    end
    sb_if.st_valid = 1'b0;
    sb_if.ld_addr  = 32'h404;
    neg();
    chk("t6_pre_count", sb_if.count, 3);
    chk("t6_pre_hit", sb_if.ld_hit, 1);
    chk("t6_pre_data", sb_if.ld_data, 32'h42);
    step();
    reset           = 1'b1;
    sb_if.mem_ready = 1'b1;
    step();
    reset           = 1'b0;
    sb_if.mem_ready = 1'b0;
    neg();
    chk("t6_count", sb_if.count, 0);
    chk("t6_mem_valid", sb_if.mem_valid, 0);
    chk("t6_ld_hit", sb_if.ld_hit, 0);
    chk("t6_empty", sb_if.empty, 1);
    step();

    // repeated store to the youngest entry
    store(32'h10, 32'h1);
    step();
    store(32'h20, 32'h2);
    step();
    store(32'h20, 32'h77);
    step();
    sb_if.st_valid = 1'b0;
    sb_if.ld_addr  = 32'h20;
    push(32'h10, 32'h1);
`ifdef STORE_BUF_COALESCE_EN
    push(32'h20, 32'h77);
`else
    push(32'h20, 32'h2);
    push(32'h20, 32'h77);
`endif
    neg();
`ifdef STORE_BUF_COALESCE_EN
    chk("t7_count", sb_if.count, 2);
`else
    chk("t7_count", sb_if.count, 3);
`endif
    chk("t7_hit", sb_if.ld_hit, 1);
    chk("t7_data", sb_if.ld_data, 32'h77);
    step();
    sb_if.mem_ready = 1'b1;
    wait_empty("t7_drain");

    neg();
    chk("sb_all_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Posted-write buffer between the pipeline's memory stage (MemWrite / DataAdr / WriteData) and data memory.
- Stores retire from the pipeline into a small circular FIFO, then drain to memory over a valid/ready handshake.
- Loads are forwarded from the youngest matching buffered store so they always see program-order data.
- A full buffer raises a stall toward the hazard unit.

Parameters:
- DEPTH, 4, number of entries (power of two, >=2)
- AW, 32, byte address width
- DW, 32, data width (word stores only)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- st_valid  in  1  store request from M stage (MemWrite)
- st_addr  in  AW  store byte address (DataAdr)
- st_data  in  DW  store data (WriteDataM)
- st_ready  out  1  buffer can accept a store this cycle
- stall  out  1  = st_valid & ~st_ready; to hazard unit (hold F/D/E/M)
- ld_addr  in  AW  load byte address (ALUResultM)
- ld_hit  out  1  a buffered store matches ld_addr
- ld_data  out  DW  youngest matching store data (valid when ld_hit)
- mem_valid  out  1  head entry presented to memory
- mem_ready  in  1  memory accepts head this cycle
- mem_addr  out  AW  head address, {word_addr, 2'b00}
- mem_data  out  DW  head data
- count  out  $clog2(DEPTH+1)  occupied entries
- empty  out  1  count == 0

Behaviour:
- Reset: rd_ptr, wr_ptr and count are 0; all entry valid bits clear; mem_valid=0, ld_hit=0, st_ready=1, stall=0, empty=1. Entry payloads are not reset. Reset mid-operation discards all buffered stores; no mem handshake completes on the reset cycle.
- Addressing: only st_addr[AW-1:2] is stored; bits [1:0] are ignored. Loads compare ld_addr[AW-1:2].
- Enqueue: st_valid & st_ready at posedge writes entry[wr_ptr], sets its valid bit, and increments wr_ptr modulo DEPTH.
- Dequeue: mem_valid & mem_ready at posedge clears entry[rd_ptr] and increments rd_ptr modulo DEPTH.
- count: +1 on enqueue only, -1 on dequeue only, unchanged when both occur.
- st_ready = (count != DEPTH). It is state-derived only, with no combinational path from mem_ready. When full, a store is refused even in a cycle where a dequeue occurs; it is accepted the next cycle.
- mem_valid = ~empty. mem_addr and mem_data come from entry[rd_ptr] and are stable while mem_valid & ~mem_ready.
- Enqueue latency: 1 cycle. A store accepted into an empty buffer presents mem_valid on the following cycle (no bypass).
- Forwarding (combinational):
  - Compare ld_addr word against every valid entry.
  - Youngest match wins: search from wr_ptr-1 backward to rd_ptr.
  - The head entry being dequeued this cycle still forwards.
  - A store enqueued in the same cycle does not forward.
  - No match: ld_hit=0, ld_data=0.
- Pointer wrap: pointers carry no extra wrap bit; full/empty are decided by count.

Optional Feature:
- Macro: STORE_BUF_COALESCE_EN.
- Defined: an incoming store whose word address equals the youngest entry (wr_ptr-1), with count>=2 so that entry is not the head, overwrites that entry's data in place. Pointers and count are unchanged. st_ready is forced to 1 for such a store even when full.
- Undefined: every accepted store allocates a new entry.

Decomposition:
- Package store_buf_pkg:
  - WORD_AW = AW-2
  - typedef sb_entry_t struct {logic valid; logic [WORD_AW-1:0] waddr; logic [DW-1:0] data}
  - function ptr_inc (modulo DEPTH)
- Sub-module sb_fwd_match: purely combinational youngest-first priority match over the entry array and pointers; outputs hit and data.

Test Plan:
- After reset, store 0x19 to 0x64 with mem_ready=1: mem_valid=1 next cycle with mem_addr=0x64, mem_data=0x19; count returns 0 one cycle later; stall stays 0.
- mem_ready=0, five consecutive stores of 1..5 to 0x100..0x110: first four accepted (count=4, st_ready=0), fifth raises stall. With mem_ready=1, one drain is followed by acceptance of the fifth store next cycle.
- Stores 0xA then 0xB to 0x200 with mem_ready=0, then ld_addr=0x202: ld_hit=1, ld_data=0xB. ld_addr=0x204: ld_hit=0.
- Backpressure: hold mem_ready=0 for 3 cycles with one entry: mem_addr/mem_data stable; drain order matches enqueue order across pointer wrap (8+ stores, DEPTH=4).
- Reset asserted with count=3: next cycle count=0, mem_valid=0, ld_hit=0 for previously buffered addresses.
- STORE_BUF_COALESCE_EN, mem_ready=0, stores to 0x10, 0x20, then 0x20 (data 0x77): count=2, ld_addr=0x20 gives 0x77. Undefined: count=3.
